// File: rtl/mem_arbiter_pkg.sv
// Shared types for the LC-3b L1 memory arbiter: line type, arbiter states and grant encoding.
package mem_arbiter_pkg;

    localparam int ARB_ADDR_W = 16;
    localparam int ARB_LINE_W = 128;

    typedef logic [ARB_LINE_W-1:0] lc3b_line;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } lc3b_arb_state;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_picker2.sv
// Two-way round-robin picker: one-hot grant (bit 0 = I, bit 1 = D), favouring the side not granted last.
module rr_picker2
    import mem_arbiter_pkg::*;
(
    input  logic       i_reqI,
    input  logic       i_reqD,
    input  logic       i_lastGrant,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = 2'b00;
        if (i_reqI && i_reqD) begin
            o_grant = (i_lastGrant == GRANT_I) ? 2'b10 : 2'b01;
        end else if (i_reqI) begin
            o_grant = 2'b01;
        end else if (i_reqD) begin
            o_grant = 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory port between the L1 icache and dcache, one line transaction at a time.
// Optional grant/conflict counters are built when MEM_ARB_PERF_CNT_EN is defined.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int LINE_W = ARB_LINE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]       i_grant_cnt,
    output logic [31:0]       d_grant_cnt,
    output logic [31:0]       conflict_cnt
`endif
);

    lc3b_arb_state r_state;
    lc3b_arb_state w_nextState;
    logic          r_lastGrant;
    logic          w_nextLastGrant;
    logic          w_reqD;
    logic [1:0]    w_grant;

    assign w_reqD  = d_read | d_write;
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

    rr_picker2 u_picker (
        .i_reqI      (i_read),
        .i_reqD      (w_reqD),
        .i_lastGrant (r_lastGrant),
        .o_grant     (w_grant)
    );

    // last_grant records every grant, so a cache that just won loses the next tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_lastGrant <= GRANT_I;
        end else begin
            r_state     <= w_nextState;
            r_lastGrant <= w_nextLastGrant;
        end
    end

    always_comb begin
        w_nextState     = r_state;
        w_nextLastGrant = r_lastGrant;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_address     = '0;
        mem_wdata       = '0;
        i_resp          = 1'b0;
        d_resp          = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant[0]) begin
                    w_nextState     = SERVE_I;
                    w_nextLastGrant = GRANT_I;
                end else if (w_grant[1]) begin
                    w_nextState     = SERVE_D;
                    w_nextLastGrant = GRANT_D;
                end
            end
            SERVE_I: begin
                mem_read    = 1'b1;
                mem_address = i_address;
                if (!i_read) begin
                    w_nextState = IDLE;
                end else if (mem_resp) begin
                    i_resp      = 1'b1;
                    w_nextState = IDLE;
                end
            end
            SERVE_D: begin
                // A simultaneous read and write is illegal; the write is honoured.
                mem_write   = d_write;
                mem_read    = d_read & ~d_write;
                mem_address = d_address;
                mem_wdata   = d_wdata;
                if (!w_reqD) begin
                    w_nextState = IDLE;
                end else if (mem_resp) begin
                    d_resp      = 1'b1;
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    assert property (@(posedge clk) disable iff (!rst_n) (r_state == SERVE_I) |-> i_read);
    assert property (@(posedge clk) disable iff (!rst_n) (r_state == SERVE_D) |-> w_reqD);

`ifdef MEM_ARB_PERF_CNT_EN
    logic w_startI;
    logic w_startD;
    logic w_conflict;

    assign w_startI   = (r_state == IDLE) & w_grant[0];
    assign w_startD   = (r_state == IDLE) & w_grant[1];
    assign w_conflict = ((r_state == IDLE) & i_read & w_reqD)
                      | ((r_state == SERVE_I) & w_reqD)
                      | ((r_state == SERVE_D) & i_read);

    // Counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_grant_cnt  <= '0;
            d_grant_cnt  <= '0;
            conflict_cnt <= '0;
        end else begin
            if (w_startI && (i_grant_cnt != '1)) begin
                i_grant_cnt <= i_grant_cnt + 32'd1;
            end
            if (w_startD && (d_grant_cnt != '1)) begin
                d_grant_cnt <= d_grant_cnt + 32'd1;
            end
            if (w_conflict && (conflict_cnt != '1)) begin
                conflict_cnt <= conflict_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single physical memory port between the split L1 instruction cache and the L1 data cache of the LC-3b pipeline.
- Sits between the two cache miss/writeback interfaces and the memory-side port: mem_read, mem_write, mem_address, mem_rdata, mem_wdata, mem_resp.
- Grants one cache per line transaction and forwards that cache's request to memory. Returns the response only to the granted cache.
- Arbitration is round-robin when both caches contend.

Parameters:
- ADDR_W, 16, byte address width (matches lc3b_word).
- LINE_W, 128, cache line width in bits.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- i_read  in  1  icache line-read request, held until i_resp
- i_address  in  ADDR_W  icache line address
- i_rdata  out  LINE_W  line data to icache
- i_resp  out  1  one-cycle completion pulse to icache
- d_read  in  1  dcache line-read request, held until d_resp
- d_write  in  1  dcache line-writeback request, held until d_resp
- d_address  in  ADDR_W  dcache line address
- d_wdata  in  LINE_W  dcache writeback line
- d_rdata  out  LINE_W  line data to dcache
- d_resp  out  1  one-cycle completion pulse to dcache
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_address  out  ADDR_W  memory line address
- mem_wdata  out  LINE_W  memory write line
- mem_rdata  in  LINE_W  memory read line
- mem_resp  in  1  memory completion, one cycle

Behaviour:
- State machine: IDLE, SERVE_I, SERVE_D.
- Register last_grant (0 = I, 1 = D) implements round-robin.
- Reset, asserted at any time including mid-transaction:
  - state = IDLE, last_grant = I.
  - All strobes and resps are 0; mem_address and mem_wdata are 0.
  - Any in-flight memory transaction is abandoned. Memory sees its strobe drop immediately.
- IDLE transitions:
  - Only i_read asserted -> SERVE_I.
  - Only d_read or d_write asserted -> SERVE_D.
  - Both caches requesting -> grant the cache not equal to last_grant, then update last_grant.
  - Neither requesting -> stay in IDLE.
  - No memory strobe is driven in IDLE, so the grant decision costs one cycle.
- SERVE_I:
  - mem_read = 1, mem_write = 0, mem_address = i_address, mem_wdata = 0.
- SERVE_D:
  - mem_read = d_read, mem_write = d_write, mem_address = d_address, mem_wdata = d_wdata.
  - If d_read and d_write are both asserted (illegal), write wins and mem_read is forced to 0.
- Strobe outputs are combinational from state and the live request inputs.
- Response path:
  - In SERVE_x, when mem_resp = 1: x_resp = 1 in the same cycle (combinational), x_rdata = mem_rdata, next state = IDLE.
  - The non-granted cache's resp stays 0.
  - i_rdata and d_rdata are both wired to mem_rdata at all times. They are only meaningful when the matching resp is high.
- Requester protocol:
  - A requester may drop its request only in the cycle after its resp.
  - If the granted requester drops its request before mem_resp, the arbiter returns to IDLE next cycle and ignores any later mem_resp. This is a simulation assertion error.
- Back-to-back: after a resp, the arbiter is in IDLE for one cycle. A still-pending other cache is granted in that IDLE cycle. Maximum wait for either cache is one full transaction of the other plus one cycle, so there is no starvation.
- mem_resp arriving in IDLE is ignored.

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN.
- When defined, three 32-bit saturating counters are added, each read-only:
  - i_grant_cnt: increments on each IDLE->SERVE_I transition.
  - d_grant_cnt: increments on each IDLE->SERVE_D transition.
  - conflict_cnt: increments every cycle in which a cache has a pending request but is not granted.
- All three counters reset to 0 on rst_n and are exposed as output ports of the same names.
- When not defined: no counters and no extra ports. Behaviour is otherwise identical.

Decomposition:
- lc3b_types gains:
  - lc3b_line: a LINE_W-bit line type.
  - lc3b_arb_state: an enum of IDLE, SERVE_I, SERVE_D.
- The round-robin pick is a natural sub-module, rr_picker2: two request inputs, a last_grant input, a one-hot grant output. It is purely combinational and is reused later for the L2 arbiter.

Test Plan:
- Reset mid-SERVE_D with d_write = 1 -> mem_write drops to 0 asynchronously; state is IDLE after release; d_resp is never asserted.
- i_read alone, i_address = 0x1230, mem_resp after 5 cycles with mem_rdata = 0xDEADBEEF... -> mem_read = 1 from cycle 1, i_resp pulses 1 cycle with matching i_rdata, d_resp = 0.
- Simultaneous i_read and d_read from reset (last_grant = I) -> dcache is served first, then icache on the cycle after d_resp; mem_address switches from d_address to i_address.
- d_write with d_address = 0x0040, d_wdata = 0xA5A5... -> mem_write = 1, mem_wdata matches, mem_read = 0; d_resp on mem_resp.
- Both caches request continuously for 6 transactions -> grants alternate D, I, D, I, D, I; no cache waits more than one transaction.
- Spurious mem_resp in IDLE -> i_resp = 0, d_resp = 0, state is unchanged; with MEM_ARB_PERF_CNT_EN, counters are unchanged.
